// File: rtl/graph_gen.sv
// graph_gen: fills a table of N_POINTS (x,y) coordinates from an xorshift32
// stream, with rejection sampling against per-axis exclusive limits, a
// start/busy/done handshake, a registered read port and a write-stream tap.
module graph_gen #(
    parameter int          N_POINTS     = 64,
    parameter int          COORD_W      = 8,
    parameter logic [31:0] DEFAULT_SEED = 32'd27182818
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [31:0]                       seed,
    input  logic [COORD_W:0]                  x_lim,
    input  logic [COORD_W:0]                  y_lim,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(N_POINTS+1)-1:0]     count,
    input  logic [$clog2(N_POINTS)-1:0]       rd_addr,
    output logic [COORD_W-1:0]                rd_x,
    output logic [COORD_W-1:0]                rd_y,
    output logic                              wr_valid,
    output logic [$clog2(N_POINTS)-1:0]       wr_addr,
    output logic [COORD_W-1:0]                wr_x,
    output logic [COORD_W-1:0]                wr_y
);

    localparam int AW = $clog2(N_POINTS);
    localparam int CW = $clog2(N_POINTS+1);
    localparam int LW = COORD_W + 1;

    // A latched limit of 0 stands for the full 2^COORD_W range.
    localparam logic [LW-1:0] FULL_RANGE = {1'b1, {COORD_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t              state_q, state_d;
    logic [31:0]         rng_q, rng_d;
    logic [LW-1:0]       xlim_q, xlim_d;
    logic [LW-1:0]       ylim_q, ylim_d;
    logic [CW-1:0]       count_q, count_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wr_valid_q, wr_valid_d;
    logic [AW-1:0]       wr_addr_q, wr_addr_d;
    logic [COORD_W-1:0]  wr_x_q, wr_x_d;
    logic [COORD_W-1:0]  wr_y_q, wr_y_d;
    logic [COORD_W-1:0]  rd_x_q, rd_y_q;

    logic [2*COORD_W-1:0] tbl [N_POINTS];

    logic [31:0]         rng_next;
    logic [COORD_W-1:0]  cand_x, cand_y;
    logic [LW-1:0]       xlim_eff, ylim_eff;
    logic                accept;
    logic                last_point;

    function automatic logic [31:0] xorshift32(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 17);
        return t ^ (t << 5);
    endfunction

    assign rng_next   = xorshift32(rng_q);
    assign cand_x     = rng_next[COORD_W-1:0];
    assign cand_y     = rng_next[16+COORD_W-1:16];
    assign xlim_eff   = (xlim_q == '0) ? FULL_RANGE : xlim_q;
    assign ylim_eff   = (ylim_q == '0) ? FULL_RANGE : ylim_q;
    assign accept     = (state_q == FILL) &&
                        ({1'b0, cand_x} < xlim_eff) &&
                        ({1'b0, cand_y} < ylim_eff);
    assign last_point = accept && (count_q == CW'(N_POINTS - 1));

    // Next-state and output decode for the IDLE/FILL/DONE controller.
    always_comb begin
        state_d    = state_q;
        rng_d      = rng_q;
        xlim_d     = xlim_q;
        ylim_d     = ylim_q;
        count_d    = count_q;
        busy_d     = busy_q;
        done_d     = done_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    rng_d   = (seed == 32'd0) ? DEFAULT_SEED : seed;
                    xlim_d  = x_lim;
                    ylim_d  = y_lim;
                    count_d = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                // Start is deliberately ignored while filling.
                rng_d = rng_next;
                if (accept) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = count_q[AW-1:0];
                    wr_x_d     = cand_x;
                    wr_y_d     = cand_y;
                    count_d    = count_q + CW'(1);
                    if (last_point) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and write-tap registers; reset beats a coincident start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rng_q      <= DEFAULT_SEED;
            xlim_q     <= '0;
            ylim_q     <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
        end else begin
            state_q    <= state_d;
            rng_q      <= rng_d;
            xlim_q     <= xlim_d;
            ylim_q     <= ylim_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
        end
    end

    // Point table write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            tbl[count_q[AW-1:0]] <= {cand_x, cand_y};
        end
    end

    // Synchronous read port; a same-cycle write to rd_addr returns the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_x_q <= '0;
            rd_y_q <= '0;
        end else begin
            rd_x_q <= tbl[rd_addr][2*COORD_W-1:COORD_W];
            rd_y_q <= tbl[rd_addr][COORD_W-1:0];
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign rd_x     = rd_x_q;
    assign rd_y     = rd_y_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_x     = wr_x_q;
    assign wr_y     = wr_y_q;

endmodule

// File: tb/tb_graph_gen.sv
// Testbench for graph_gen (N_POINTS=64, COORD_W=8): scoreboard of expected
// write-stream entries filled at each start, popped by an independent monitor.
module tb_graph_gen;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] seed;
    logic [8:0]  x_lim, y_lim;
    logic        busy, done;
    logic [6:0]  count;
    logic [5:0]  rd_addr;
    logic [7:0]  rd_x, rd_y;
    logic        wr_valid;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_x, wr_y;

    graph_gen #(.N_POINTS(64), .COORD_W(8), .DEFAULT_SEED(32'd27182818)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .x_lim(x_lim), .y_lim(y_lim), .busy(busy), .done(done), .count(count),
        .rd_addr(rd_addr), .rd_x(rd_x), .rd_y(rd_y),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] a;
        logic [7:0] x;
        logic [7:0] y;
    } ent_t;

    ent_t       sb_q[$];
    ent_t       mon_e;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         mon_xlim = 256;
    logic [7:0] mx[N], my[N];
    logic [7:0] sx[N], sy[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] xs32(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 17);
        return t ^ (t << 5);
    endfunction

    // Monitor: every presented write is compared with the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && wr_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got addr %0d with no expected entry", wr_addr);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_addr", 32'(wr_addr), 32'(mon_e.a));
                chk("sb_x", 32'(wr_x), 32'(mon_e.x));
                chk("sb_y", 32'(wr_y), 32'(mon_e.y));
            end
            chk("wr_x_below_lim", 32'(int'(wr_x) < mon_xlim), 32'd1);
        end
    end

    task automatic model_fill(input logic [31:0] sd, input int xl, input int yl, output int steps);
        logic [31:0] s;
        logic [7:0]  cx, cy;
        ent_t        e;
        int          k;
        s = (sd == 32'd0) ? 32'd27182818 : sd;
        k = 0;
        steps = 0;
        while (k < N) begin
            s = xs32(s);
            steps++;
            cx = s[7:0];
            cy = s[23:16];
            if (int'(cx) < xl && int'(cy) < yl) begin
                mx[k] = cx;
                my[k] = cy;
                e.a = k[5:0];
                e.x = cx;
                e.y = cy;
                sb_q.push_back(e);
                k++;
            end
        end
    endtask

    // Called #1 after a posedge; returns #1 after the start edge.
    task automatic issue_start(input logic [31:0] sd, input int xl, input int yl, output int steps);
        int xe, ye;
        xe = (xl == 0) ? 256 : xl;
        ye = (yl == 0) ? 256 : yl;
        model_fill(sd, xe, ye, steps);
        mon_xlim = xe;
        seed  = sd;
        x_lim = xl[8:0];
        y_lim = yl[8:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string name, input int exp_lat, output int lat);
        while (!done && (cyc - start_cyc) < 20000) begin
            @(posedge clk);
            #1;
        end
        lat = cyc - start_cyc + 1;
        chk(name, 32'(lat), 32'(exp_lat));
        chk("done_high", 32'(done), 32'd1);
        chk("count_full", 32'(count), 32'd64);
        chk("busy_low", 32'(busy), 32'd0);
    endtask

    task automatic sweep(input bit use_saved);
        logic [7:0] ex, ey, px, py;
        for (int a = 0; a < N; a++) begin
            rd_addr = a[5:0];
            if (a > 0) begin
                #1;
                px = use_saved ? sx[a-1] : mx[a-1];
                py = use_saved ? sy[a-1] : my[a-1];
                chk("rd_x_hold", 32'(rd_x), 32'(px));
                chk("rd_y_hold", 32'(rd_y), 32'(py));
            end
            @(posedge clk);
            #1;
            ex = use_saved ? sx[a] : mx[a];
            ey = use_saved ? sy[a] : my[a];
            chk("rd_x", 32'(rd_x), 32'(ex));
            chk("rd_y", 32'(rd_y), 32'(ey));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps, lat;
        rst = 1'b1; start = 1'b0; seed = '0; x_lim = '0; y_lim = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_x", 32'(wr_x), 32'd0);
        chk("rst_wr_y", 32'(wr_y), 32'd0);
        chk("rst_rd_x", 32'(rd_x), 32'd0);
        chk("rst_rd_y", 32'(rd_y), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // seed=1 full range: first point (0x21,0x04), done 65 edges after start.
        issue_start(32'd1, 0, 0, steps);
        chk("t1_busy", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("t1_first_valid", 32'(wr_valid), 32'd1);
        chk("t1_first_addr", 32'(wr_addr), 32'd0);
        chk("t1_first_x", 32'(wr_x), 32'h21);
        chk("t1_first_y", 32'(wr_y), 32'h04);
        wait_done("t1_latency", 65, lat);
        sweep(1'b0);

        // seed=0 must behave exactly like the default seed.
        issue_start(32'd0, 0, 0, steps);
        for (int i = 0; i < N; i++) begin sx[i] = mx[i]; sy[i] = my[i]; end
        wait_done("t2a_latency", 65, lat);
        issue_start(32'd27182818, 0, 0, steps);
        wait_done("t2b_latency", 65, lat);
        sweep(1'b1);

        // seed=1, x_lim=16: first candidate x=33 rejected, extra latency.
        issue_start(32'd1, 16, 256, steps);
        @(posedge clk);
        #1;
        chk("t3_first_reject", 32'(wr_valid), 32'd0);
        wait_done("t3_latency", steps + 1, lat);
        chk("t3_latency_gt65", 32'(lat > 65), 32'd1);
        sweep(1'b0);
        mon_xlim = 256;

        // Start during FILL is ignored; start after done restarts.
        issue_start(32'd1, 0, 0, steps);
        repeat (9) @(posedge clk);
        #1;
        seed = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t4_latency", 65, lat);
        issue_start(32'd1, 0, 0, steps);
        chk("t4_restart_done_clear", 32'(done), 32'd0);
        chk("t4_restart_busy", 32'(busy), 32'd1);
        wait_done("t4_restart_latency", 65, lat);

        // Reset mid-fill at count=20, with a coincident start that must lose.
        issue_start(32'd1, 0, 0, steps);
        while (count !== 7'd20 && (cyc - start_cyc) < 200) begin
            @(posedge clk);
            #1;
        end
        chk("t5_count20", 32'(count), 32'd20);
        rst = 1'b1;
        start = 1'b1;
        seed = 32'd9;
        @(posedge clk);
        #1;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_count", 32'(count), 32'd0);
        sb_q.delete();
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_idle_busy", 32'(busy), 32'd0);
        chk("t5_idle_wr_valid", 32'(wr_valid), 32'd0);
        issue_start(32'd7, 0, 0, steps);
        wait_done("t5_regen_latency", 65, lat);
        sweep(1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
